// File: rtl/maze_pkg.sv
// rtl/maze_pkg.sv - shared maze encodings for game controller, bot and MIPS I/O decode
package maze_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SPAWN = 3'd1,
    ST_RUN   = 3'd2,
    ST_HIT   = 3'd3,
    ST_WIN   = 3'd4,
    ST_LOSE  = 3'd5
  } game_state_t;

  localparam logic [2:0] NORTH     = 3'd0;
  localparam logic [2:0] NORTHEAST = 3'd1;
  localparam logic [2:0] EAST      = 3'd2;
  localparam logic [2:0] SOUTHEAST = 3'd3;
  localparam logic [2:0] SOUTH     = 3'd4;
  localparam logic [2:0] SOUTHWEST = 3'd5;
  localparam logic [2:0] WEST      = 3'd6;
  localparam logic [2:0] NORTHWEST = 3'd7;

  localparam logic [1:0] SPD_IDLE    = 2'd0;
  localparam logic [1:0] SPD_SLOWEST = 2'd1;
  localparam logic [1:0] SPD_SLOW    = 2'd2;
  localparam logic [1:0] SPD_FAST    = 2'd3;

  localparam int DEF_TICK_DIV = 50000000;
  localparam int DEF_HIT_HOLD = 25000000;

endpackage

// File: rtl/maze_game_ctrl_if.sv
// rtl/maze_game_ctrl_if.sv - controller-to-bot drive and status bundle
interface maze_game_ctrl_if;
  logic       bot_soft_rst_n;
  logic [2:0] bot_dir;
  logic [1:0] bot_x_speed;
  logic [1:0] bot_y_speed;
  logic       bot_hit_wall;
  logic       bot_maze_end;

  modport master (
    output bot_soft_rst_n, bot_dir, bot_x_speed, bot_y_speed,
    input  bot_hit_wall, bot_maze_end
  );

  modport slave (
    input  bot_soft_rst_n, bot_dir, bot_x_speed, bot_y_speed,
    output bot_hit_wall, bot_maze_end
  );
endinterface

// File: rtl/maze_game_ctrl_sec_timer.sv
// rtl/maze_game_ctrl_sec_timer.sv - tick divider feeding a saturating seconds counter
module sec_timer #(
  parameter int TICK_DIV = 50000000,
  parameter int MAX_SEC  = 999
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  output logic [9:0] elapsed_sec
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (MAX_SEC > 0) ? $clog2(MAX_SEC + 1) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SEC_MAX   = SW'(MAX_SEC);

  logic [TW-1:0] tick_q;
  logic [SW-1:0] sec_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      tick_q <= '0;
      sec_q  <= '0;
    end else if (clr) begin
      tick_q <= '0;
      sec_q  <= '0;
    end else if (en) begin
      if (tick_q == TICK_LAST) begin
        tick_q <= '0;
        if (sec_q != SEC_MAX) sec_q <= sec_q + 1'b1;
      end else begin
        tick_q <= tick_q + 1'b1;
      end
    end
  end

  assign elapsed_sec = 10'(sec_q);

endmodule

// File: rtl/maze_game_ctrl.sv
// rtl/maze_game_ctrl.sv - game sequencer: bot spawn/respawn, run gating, lives, timer, win/lose irq
module maze_game_ctrl
  import maze_pkg::*;
#(
  parameter int TICK_DIV   = DEF_TICK_DIV,
  parameter int RST_PULSE  = 4,
  parameter int HIT_HOLD   = DEF_HIT_HOLD,
  parameter int INIT_LIVES = 3,
  parameter int MAX_SEC    = 999
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [2:0]              dir_in,
  input  logic [1:0]              x_speed_in,
  input  logic [1:0]              y_speed_in,
  maze_game_ctrl_if.master        bot,
  output logic [2:0]              state,
  output logic [1:0]              lives,
  output logic [9:0]              elapsed_sec,
  output logic                    game_won,
  output logic                    game_over,
  output logic                    irq
);

  localparam int PW = (RST_PULSE > 1) ? $clog2(RST_PULSE) : 1;
  localparam int HW = (HIT_HOLD > 1) ? $clog2(HIT_HOLD) : 1;
  localparam logic [PW-1:0] PULSE_LAST = PW'(RST_PULSE - 1);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(HIT_HOLD - 1);
  localparam logic [1:0]    LIVES_INIT = 2'(INIT_LIVES);

  game_state_t   state_q, state_d;
  logic [PW-1:0] pulse_cnt;
  logic [HW-1:0] hold_cnt;
  logic [1:0]    lives_q;
  logic          new_game;
  logic          run_hit;

  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    new_game = 1'b0;
    run_hit  = 1'b0;
    case (state_q)
      ST_IDLE: if (start) begin
        state_d  = ST_SPAWN;
        new_game = 1'b1;
      end
      ST_SPAWN: if (pulse_cnt == PULSE_LAST) state_d = ST_RUN;
      ST_RUN: begin
        // maze_end outranks a simultaneous wall hit
        if (bot.bot_maze_end) begin
          state_d = ST_WIN;
        end else if (bot.bot_hit_wall) begin
          run_hit = 1'b1;
          state_d = (lives_q > 2'd1) ? ST_HIT : ST_LOSE;
        end
      end
      ST_HIT: if (hold_cnt == HOLD_LAST) state_d = ST_SPAWN;
      ST_WIN, ST_LOSE: if (start) begin
        state_d  = ST_SPAWN;
        new_game = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    if (abort) begin
      state_d  = ST_IDLE;
      new_game = 1'b0;
      run_hit  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pulse_cnt <= '0;
      hold_cnt  <= '0;
      lives_q   <= LIVES_INIT;
    end else begin
      pulse_cnt <= (state_q == ST_SPAWN && state_d == ST_SPAWN) ? pulse_cnt + 1'b1 : '0;
      hold_cnt  <= (state_q == ST_HIT && state_d == ST_HIT) ? hold_cnt + 1'b1 : '0;
      if (new_game)     lives_q <= LIVES_INIT;
      else if (run_hit) lives_q <= lives_q - 1'b1;
    end
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (!rst) begin
      bot.bot_soft_rst_n <= 1'b0;
      bot.bot_dir        <= '0;
      bot.bot_x_speed    <= '0;
      bot.bot_y_speed    <= '0;
      game_won           <= 1'b0;
      game_over          <= 1'b0;
      irq                <= 1'b0;
    end else begin
      bot.bot_soft_rst_n <= !(state_d == ST_IDLE || state_d == ST_SPAWN);
      if (state_d == ST_RUN) begin
        bot.bot_dir     <= dir_in;
        bot.bot_x_speed <= x_speed_in;
        bot.bot_y_speed <= y_speed_in;
      end else begin
        bot.bot_x_speed <= SPD_IDLE;
        bot.bot_y_speed <= SPD_IDLE;
      end
      game_won  <= (state_d == ST_WIN);
      game_over <= (state_d == ST_LOSE);
      irq       <= (state_d == ST_WIN  && state_q != ST_WIN) ||
                   (state_d == ST_LOSE && state_q != ST_LOSE);
    end
  end

  sec_timer #(
    .TICK_DIV (TICK_DIV),
    .MAX_SEC  (MAX_SEC)
  ) u_sec_timer (
    .clk         (clk),
    .rst         (rst),
    .en          (state_q == ST_RUN),
    .clr         (new_game),
    .elapsed_sec (elapsed_sec)
  );

  assign state = state_q;
  assign lives = lives_q;

endmodule

// File: doc/maze_game_ctrl.md
Name: maze_game_ctrl

Overview:
- Game-level sequencer for the maze bot datapath.
- Owns the bot's soft reset (spawn/respawn), gates the MIPS-supplied direction/speed onto the bot only while a run is live, counts lives and elapsed seconds, and reports win/lose to MIPS via status and a one-cycle interrupt.
- Sits between the MIPS I/O registers and the maze bot.

Parameters:
- TICK_DIV, 50000000: clk cycles per elapsed-time second.
- RST_PULSE, 4: cycles bot_soft_rst_n is held low per spawn.
- HIT_HOLD, 25000000: cycles paused after a wall hit before respawn.
- INIT_LIVES, 3: lives at game start, 1..3.
- MAX_SEC, 999: elapsed-seconds saturation value.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-low
- start  in  1  MIPS pulse: begin new game
- abort  in  1  MIPS pulse: return to IDLE
- dir_in  in  3  MIPS requested direction (N=0..NW=7)
- x_speed_in  in  2  MIPS x speed (0 = idle)
- y_speed_in  in  2  MIPS y speed (0 = idle)
- bot_hit_wall  in  1  bot sticky wall-hit flag
- bot_maze_end  in  1  bot sticky maze-end flag
- bot_soft_rst_n  out  1  active-low soft reset to bot
- bot_dir  out  3  direction to bot
- bot_x_speed  out  2  x speed to bot
- bot_y_speed  out  2  y speed to bot
- state  out  3  current FSM state, MIPS readable
- lives  out  2  remaining lives
- elapsed_sec  out  10  seconds spent in RUN, saturating
- game_won  out  1  level while in WIN
- game_over  out  1  level while in LOSE
- irq  out  1  one-cycle pulse on entry to WIN or LOSE

Behaviour:

Reset values (rst=0 at clk edge):
- state=IDLE, bot_soft_rst_n=0.
- bot_dir=0, speeds=0.
- lives=INIT_LIVES, elapsed_sec=0, tick/hold/pulse counters=0.
- game_won=0, game_over=0, irq=0.

All outputs are registered.

State encoding: IDLE=0, SPAWN=1, RUN=2, HIT_HOLD=3, WIN=4, LOSE=5. Codes 6/7 go to IDLE next cycle.

Global rules:
- abort=1 in any state -> IDLE next cycle.
- abort has priority over start and over all bot flags.

IDLE:
- bot_soft_rst_n=0, speeds=0.
- start -> SPAWN; load lives=INIT_LIVES, elapsed_sec=0, tick counter=0.

SPAWN:
- bot_soft_rst_n=0 for exactly RST_PULSE cycles, counted from entry.
- Then -> RUN; bot_soft_rst_n=1 on the first RUN cycle.
- Bot flags are ignored in SPAWN.

RUN:
- bot_soft_rst_n=1.
- bot_dir/bot_x_speed/bot_y_speed = dir_in/x/y_speed_in, registered (1-cycle latency).
- Tick counter increments; at TICK_DIV-1 it wraps to 0 and elapsed_sec+1, holding at MAX_SEC.
- Flag priority: bot_maze_end -> WIN.
- Else bot_hit_wall with lives>1 -> lives-1, go to HIT_HOLD.
- Else bot_hit_wall with lives==1 -> lives=0, go to LOSE.
- If both flags are set in the same cycle, WIN is taken.
- start is ignored in RUN.

HIT_HOLD:
- Speeds=0, bot_dir holds its last value, bot_soft_rst_n=1 (bot stays deadlocked).
- Tick counter and elapsed_sec are frozen, not cleared.
- After HIT_HOLD cycles -> SPAWN; lives and elapsed_sec are kept (respawn, not a new game).

WIN / LOSE:
- Speeds=0, bot_soft_rst_n=1.
- game_won (WIN) or game_over (LOSE) is high.
- irq is high on the first cycle in the state only.
- elapsed_sec is frozen.
- start -> SPAWN as a new game: lives=INIT_LIVES, elapsed_sec=0, flags clear.

Outside RUN: speeds are forced to 0 every cycle.

Counter widths: each counter is sized to its parameter ($clog2). All comparisons are unsigned.

Reset mid-game: takes effect on the next edge regardless of state, including a pending irq.

Decomposition:
- Package maze_pkg:
  - state encodings;
  - direction constants NORTH..NORTHWEST;
  - speed constants IDLE/SLOWEST/SLOW/FAST;
  - default TICK_DIV / HIT_HOLD values.
- maze_pkg is shared with the bot and the MIPS I/O decode.
- Sub-module sec_timer:
  - tick divider plus saturating seconds counter;
  - inputs: clk, rst, en, clr;
  - output: elapsed_sec.
  - Instantiated once, en = (state==RUN).

Test Plan (TICK_DIV=10, RST_PULSE=4, HIT_HOLD=8, INIT_LIVES=3, MAX_SEC=5):
1. Reset, then start pulse -> SPAWN; bot_soft_rst_n low for exactly 4 cycles; RUN with soft_rst_n=1; dir_in=2, x_speed_in=3 appear on bot outputs 1 cycle later.
2. Stay in RUN for 35 cycles -> elapsed_sec=3. Then run 100 more cycles -> elapsed_sec saturates at 5.
3. Assert bot_hit_wall in RUN:
   - lives 3->2, state=HIT_HOLD, speeds 0 during the hold;
   - after 8 cycles SPAWN (4-cycle soft reset) then RUN;
   - elapsed_sec is unchanged across the hold.
4. Three wall hits -> lives=0, state=LOSE, game_over=1, irq high for exactly one cycle. Then start -> SPAWN with lives=3, elapsed_sec=0.
5. bot_maze_end and bot_hit_wall high in the same RUN cycle -> WIN, game_won=1, lives unchanged, one irq pulse.
6. abort and start asserted together in RUN -> IDLE, bot_soft_rst_n=0. Then rst=0 mid-HIT_HOLD -> all outputs at reset values next cycle.
